// File: rtl/wb_mtimer.sv
// wb_mtimer: Wishbone classic RISC-V machine timer (mtime/mtimecmp).
// Build option: WB_MTIMER_SHADOW_EN adds a torn-free LO-then-HI read shadow.
// Ports: wb_clk_i/wb_rst_i clock and sync reset; wb_adr_i/dat_i/sel_i/we_i/
//   cyc_i/stb_i bus inputs; wb_dat_o/ack_o bus outputs; timer_irq_o level irq.
module wb_mtimer #(
  parameter logic [15:0] RESET_DIV    = 16'd0,
  parameter logic        RESET_ENABLE = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        timer_irq_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ack_q;
  logic [31:0] dat_q, dat_d;
  logic        irq_q;
  logic [31:0] rdata;
  logic        acc, wr, rd, tick;
  logic [2:0]  adr;
  logic        unused_adr;

  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
  assign adr  = wb_adr_i[4:2];
  assign acc  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr   = acc & wb_we_i;
  assign rd   = acc & ~wb_we_i;
  assign tick = en_q && (cnt_q == div_q);

  function automatic logic [31:0] bmerge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

`ifdef WB_MTIMER_SHADOW_EN
  logic [31:0] shad_q, shad_d;
`endif

  always_comb begin
    // A bus write to either mtime half overrides the tick of that cycle.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    if (en_q) cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    if (wr) begin
      case (adr)
        3'd0: mtime_d = {mtime_q[63:32],
                         bmerge(mtime_q[31:0], wb_dat_i, wb_sel_i)};
        3'd1: mtime_d = {bmerge(mtime_q[63:32], wb_dat_i, wb_sel_i),
                         mtime_q[31:0]};
        3'd2: cmp_d[31:0]  = bmerge(cmp_q[31:0], wb_dat_i, wb_sel_i);
        3'd3: cmp_d[63:32] = bmerge(cmp_q[63:32], wb_dat_i, wb_sel_i);
        3'd4: begin
          if (wb_sel_i[0]) en_d = wb_dat_i[0];
          if (wb_sel_i[2]) div_d[7:0]  = wb_dat_i[23:16];
          if (wb_sel_i[3]) div_d[15:8] = wb_dat_i[31:24];
          cnt_d = 16'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_MTIMER_SHADOW_EN
  always_comb begin
    shad_d = shad_q;
    if (rd && adr == 3'd0) shad_d = mtime_q[63:32];
    if (wr && adr == 3'd1) shad_d = mtime_d[63:32];
  end
`endif

  always_comb begin
    rdata = 32'd0;
    case (adr)
      3'd0: rdata = mtime_q[31:0];
`ifdef WB_MTIMER_SHADOW_EN
      3'd1: rdata = shad_q;
`else
      3'd1: rdata = mtime_q[63:32];
`endif
      3'd2: rdata = cmp_q[31:0];
      3'd3: rdata = cmp_q[63:32];
      3'd4: rdata = {div_q, 15'd0, en_q};
      3'd5: rdata = {31'd0, irq_q};
      default: rdata = 32'd0;
    endcase
    dat_d = acc ? rdata : 32'd0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mtime_q <= 64'd0;
      cmp_q   <= {64{1'b1}};
      en_q    <= RESET_ENABLE;
      div_q   <= RESET_DIV;
      cnt_q   <= 16'd0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ack_q   <= acc;
      dat_q   <= dat_d;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

`ifdef WB_MTIMER_SHADOW_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) shad_q <= 32'd0;
    else          shad_q <= shad_d;
  end
`endif

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign timer_irq_o = irq_q;

endmodule
